// File: rtl/led_chain_sequencer.sv
// led_chain_sequencer: walks one lit LED across BOARDS chained boards of
// SEG_W LEDs each. Bits [SEG_W-1:0] drive the local board; each higher
// SEG_W slice feeds the next slave board in chain order.
module led_chain_sequencer #(
  parameter int CLK_DIV = 50_000_000,
  parameter int BOARDS  = 3,
  parameter int SEG_W   = 8,
  localparam int N  = BOARDS * SEG_W,
  localparam int PW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          hold,
  input  logic [1:0]    mode,
  output logic [N-1:0]  led_seq,
  output logic [PW-1:0] pos,
  output logic          step,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [1:0]    M_ONESHOT = 2'd0;
  localparam logic [1:0]    M_BOUNCE  = 2'd2;
  localparam logic [PW-1:0] LAST      = PW'(N - 1);
  localparam logic [CW-1:0] CNT_TOP   = CW'(CLK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;     // 0 = up, 1 = down (BOUNCE only)
  logic [1:0]    mode_q, mode_d;
  logic          step_d, busy_d, done_d, lit_d;
  logic [N-1:0]  hot_d, led_d;

  // One-hot decode of the next position, one comparator per LED.
  for (genvar i = 0; i < N; i++) begin : g_hot
    assign hot_d[i] = (pos_d == PW'(i));
  end

  // Next-state: stop beats start, start beats hold, hold beats the divider.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    step_d  = 1'b0;
    if (stop) begin
      state_d = S_IDLE;
      pos_d   = '0;
      cnt_d   = '0;
      dir_d   = 1'b0;
    end else if (start) begin
      state_d = S_RUN;
      pos_d   = '0;
      cnt_d   = '0;
      dir_d   = 1'b0;
      mode_d  = mode;
    end else if (state_q == S_RUN || state_q == S_PAUSE) begin
      if (hold) begin
        state_d = S_PAUSE;
      end else begin
        // Leaving PAUSE counts this cycle, so a hold freezes exactly the
        // cycles it was high for.
        state_d = S_RUN;
        if (cnt_q == CNT_TOP) begin
          cnt_d  = '0;
          step_d = 1'b1;
          if (mode_q == M_ONESHOT) begin
            if (pos_q == LAST) state_d = S_DONE;
            else               pos_d   = pos_q + PW'(1);
          end else if (mode_q == M_BOUNCE) begin
            if (N == 1) begin
              pos_d = '0;
            end else if (!dir_q) begin
              if (pos_q == LAST) begin
                dir_d = 1'b1;
                pos_d = LAST - PW'(1);
              end else begin
                pos_d = pos_q + PW'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = 1'b0;
                pos_d = PW'(1);
              end else begin
                pos_d = pos_q - PW'(1);
              end
            end
          end else begin
            // LOOP (mode 1 and 3)
            pos_d = (pos_q == LAST) ? '0 : pos_q + PW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
    lit_d  = (state_d == S_RUN) || (state_d == S_PAUSE);
    led_d  = lit_d ? hot_d : '0;
    busy_d = lit_d;
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= '0;
      led_seq <= '0;
      step    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      led_seq <= led_d;
      step    <= step_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  assign pos = pos_q;

endmodule

// File: tb/tb_led_chain_sequencer.sv
// Scoreboard bench for led_chain_sequencer: a stimulus process drives inputs
// and pushes the expected outputs computed from elapsed active cycles; a
// monitor pops and compares after every clock edge.
module tb_led_chain_sequencer;

  localparam int CLK_DIV = 4;
  localparam int BOARDS  = 3;
  localparam int SEG_W   = 8;
  localparam int N       = BOARDS * SEG_W;
  localparam int PW      = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [N-1:0]  led_seq;
  logic [PW-1:0] pos;
  logic          step, busy, done;

  led_chain_sequencer #(.CLK_DIV(CLK_DIV), .BOARDS(BOARDS), .SEG_W(SEG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .mode(mode),
    .led_seq(led_seq), .pos(pos), .step(step), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] led;
    int           pos;
    bit           chk_pos;
    bit           step;
    bit           busy;
    bit           done;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: running flag, done flag, active cycles since start.
  bit       m_run = 0, m_done = 0;
  int       m_act = 0;
  logic [1:0] m_mode = 2'd0;

  // Position after k steps, from the sequence shape of each mode.
  function automatic int pos_of(int k, logic [1:0] md);
    int per, p;
    if (md == 2'd0) return k;
    if (md == 2'd2) begin
      if (N == 1) return 0;
      per = 2 * (N - 1);
      p = k % per;
      return (p < N) ? p : per - p;
    end
    return k % N;
  endfunction

  task automatic cyc(input bit r, input bit s, input bit p, input bit h,
                     input logic [1:0] m);
    exp_t e;
    int   k;
    @(negedge clk);
    rst = r; start = s; stop = p; hold = h; mode = m;
    e.step = 0;
    if (r || p) begin
      m_run = 0; m_done = 0; m_act = 0;
    end else if (s) begin
      m_run = 1; m_done = 0; m_act = 0; m_mode = m;
    end else if (m_run && !h) begin
      m_act++;
      if (m_act % CLK_DIV == 0) e.step = 1;
      if (m_mode == 2'd0 && m_act / CLK_DIV >= N) begin
        m_run = 0; m_done = 1;
      end
    end
    k = m_act / CLK_DIV;
    e.led = '0;
    e.pos = 0;
    e.chk_pos = !m_done;
    if (m_run) begin
      e.pos = pos_of(k, m_mode);
      e.led[e.pos] = 1'b1;
    end
    e.busy = m_run;
    e.done = m_done;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n, input logic [1:0] m);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, m);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("led_seq", 64'(led_seq), 64'(e.led));
        chk("step", 64'(step), 64'(e.step));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("done", 64'(done), 64'(e.done));
        if (e.chk_pos) chk("pos", 64'(pos), 64'(e.pos));
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // ONESHOT to completion, mode wiggled mid-run, then restart from DONE.
    cyc(0, 1, 0, 0, 2'd0);
    idle(50, 2'd1);
    idle(55, 2'd2);
    cyc(0, 1, 0, 0, 2'd0);
    idle(100, 2'd0);
    cyc(0, 0, 1, 0, 2'd0);               // stop from DONE
    idle(3, 2'd0);
    // LOOP past the wrap.
    cyc(0, 1, 0, 0, 2'd1);
    idle(110, 2'd0);
    // BOUNCE through both turnarounds.
    cyc(0, 1, 0, 0, 2'd2);
    idle(200, 2'd3);
    // Hold for 10 cycles shortly after a step.
    cyc(0, 1, 0, 0, 2'd1);
    idle(6, 2'd1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 2'd1);
    idle(10, 2'd1);
    // Reset for 2 cycles mid-run.
    cyc(1, 0, 0, 0, 2'd1);
    cyc(1, 0, 0, 0, 2'd1);
    idle(3, 2'd1);
    // start+stop together while running.
    cyc(0, 1, 0, 0, 2'd3);
    idle(10, 2'd3);
    cyc(0, 1, 1, 0, 2'd3);
    idle(4, 2'd3);
    // Restart from pos 7.
    cyc(0, 1, 0, 0, 2'd1);
    idle(28, 2'd1);
    cyc(0, 1, 0, 0, 2'd2);
    idle(8, 2'd2);
    // Start while paused.
    cyc(0, 0, 0, 1, 2'd2);
    cyc(0, 1, 0, 1, 2'd0);
    idle(6, 2'd0);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      automatic bit r = ($urandom_range(0, 399) == 0);
      automatic bit s = ($urandom_range(0, 99) < 2);
      automatic bit p = ($urandom_range(0, 199) == 0);
      automatic bit h = ($urandom_range(0, 9) == 0);
      cyc(r, s, p, h, 2'($urandom_range(0, 3)));
    end
    idle(2, 2'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
